// File: rtl/qm_fir_pkg.sv
// Shared constants for the quadrature-modulation filter bank output path:
// default sample width, per-frame word indices and the read FSM state type.
package qm_fir_pkg;

    localparam int OWIDTH_DEFAULT = 16;
    localparam int QM_FRAME_WORDS = 6;

    localparam logic [2:0] QM_CH_R1 = 3'd0;
    localparam logic [2:0] QM_CH_I1 = 3'd1;
    localparam logic [2:0] QM_CH_R2 = 3'd2;
    localparam logic [2:0] QM_CH_I2 = 3'd3;
    localparam logic [2:0] QM_CH_R3 = 3'd4;
    localparam logic [2:0] QM_CH_I3 = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } qm_rd_state_e;

    // Word index advance, wrapping after the last word of a frame.
    function automatic logic [2:0] qm_idx_inc(input logic [2:0] idx);
        return (idx == QM_CH_I3) ? QM_CH_R1 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/qm_out_serializer_if.sv
// Frame capture / word stream bundle of qm_out_serializer.
// DropCount/DropClr exist only when QMSER_DROP_COUNT_EN is defined.
interface qm_out_serializer_if
    import qm_fir_pkg::*;
#(
    parameter int OWIDTH = OWIDTH_DEFAULT,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                     DataValid;
    logic signed [OWIDTH-1:0] RealIn1;
    logic signed [OWIDTH-1:0] RealIn2;
    logic signed [OWIDTH-1:0] RealIn3;
    logic signed [OWIDTH-1:0] ImagIn1;
    logic signed [OWIDTH-1:0] ImagIn2;
    logic signed [OWIDTH-1:0] ImagIn3;
    logic                     OutReady;
    logic                     OutValid;
    logic        [OWIDTH-1:0] OutData;
    logic        [2:0]        OutChan;
    logic                     OutLast;
    logic                     DropPulse;
    logic        [CW-1:0]     FrameCnt;
`ifdef QMSER_DROP_COUNT_EN
    logic                     DropClr;
    logic        [15:0]       DropCount;
`endif

    modport slave (
`ifdef QMSER_DROP_COUNT_EN
        input  DropClr,
        output DropCount,
`endif
        input  DataValid, RealIn1, RealIn2, RealIn3,
        input  ImagIn1, ImagIn2, ImagIn3, OutReady,
        output OutValid, OutData, OutChan, OutLast, DropPulse, FrameCnt
    );

    modport master (
`ifdef QMSER_DROP_COUNT_EN
        output DropClr,
        input  DropCount,
`endif
        output DataValid, RealIn1, RealIn2, RealIn3,
        output ImagIn1, ImagIn2, ImagIn3, OutReady,
        input  OutValid, OutData, OutChan, OutLast, DropPulse, FrameCnt
    );

endinterface

// File: rtl/qm_frame_fifo.sv
// Frame FIFO: DEPTH slots of six packed words (word 0 = R1 in the LSBs).
// Exposes the head frame and its successor combinationally.
module qm_frame_fifo
    import qm_fir_pkg::*;
#(
    parameter  int OWIDTH = OWIDTH_DEFAULT,
    parameter  int DEPTH  = 4,
    localparam int FW     = QM_FRAME_WORDS * OWIDTH,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [FW-1:0] din,
    output logic [FW-1:0] head,
    output logic [FW-1:0] head_succ,
    output logic [CW-1:0] count
);

    logic [FW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // When full, a simultaneous push lands in the slot being popped.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head      = mem[rd_ptr];
    assign head_succ = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/qm_out_serializer.sv
// Captures six-channel filter-bank frames into a frame FIFO and streams them
// out word by word (R1,I1,R2,I2,R3,I3). Optional drop counter: QMSER_DROP_COUNT_EN.
//
//   state   | meaning
//   --------+---------------------------------------------------
//   ST_IDLE | no frame held, OutValid low
//   ST_SEND | head frame word idx presented, advance on transfer
module qm_out_serializer
    import qm_fir_pkg::*;
#(
    parameter int OWIDTH = OWIDTH_DEFAULT,
    parameter int DEPTH  = 4
) (
    input  logic                CLK,
    input  logic                ARST,
    qm_out_serializer_if.slave  bus
);

    localparam int FW = QM_FRAME_WORDS * OWIDTH;
    localparam int CW = $clog2(DEPTH) + 1;

    qm_rd_state_e state;
    qm_rd_state_e state_next;
    logic [2:0]   idx;
    logic [2:0]   idx_next;

    logic          transfer;
    logic          pop;
    logic          push;
    logic          drop;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [FW-1:0] din;
    logic [FW-1:0] head;
    logic [FW-1:0] head_succ;
    logic [FW-1:0] frame_next;
    logic [OWIDTH-1:0] word_next;

    logic              out_valid;
    logic [OWIDTH-1:0] out_data;
    logic [2:0]        out_chan;
    logic              out_last;
    logic              drop_pulse;

    assign din = {bus.ImagIn3, bus.RealIn3, bus.ImagIn2,
                  bus.RealIn2, bus.ImagIn1, bus.RealIn1};

    qm_frame_fifo #(
        .OWIDTH (OWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (ARST),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .head      (head),
        .head_succ (head_succ),
        .count     (cnt)
    );

    always_ff @(posedge CLK) begin
        if (ARST) begin
            state <= ST_IDLE;
            idx   <= QM_CH_R1;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Outputs are registered from the post-edge view, so a frame written into
    // an empty FIFO is presented on the very next cycle.
    always_comb begin
        transfer   = (state == ST_SEND) && bus.OutReady;
        pop        = transfer && (idx == QM_CH_I3);
        push       = bus.DataValid && ((cnt < CW'(DEPTH)) || pop);
        drop       = bus.DataValid && !push;
        cnt_next   = cnt + CW'(push) - CW'(pop);
        idx_next   = transfer ? qm_idx_inc(idx) : idx;
        state_next = (cnt_next != '0) ? ST_SEND : ST_IDLE;

        if ((cnt - CW'(pop)) == '0) frame_next = din;
        else if (pop)               frame_next = head_succ;
        else                        frame_next = head;

        word_next = '0;
        for (int w = 0; w < QM_FRAME_WORDS; w++) begin
            if (idx_next == 3'(w)) word_next = frame_next[w*OWIDTH +: OWIDTH];
        end
    end

    always_ff @(posedge CLK) begin
        if (ARST) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= QM_CH_R1;
            out_last   <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            out_valid  <= (state_next == ST_SEND);
            out_data   <= (state_next == ST_SEND) ? word_next : '0;
            out_chan   <= (state_next == ST_SEND) ? idx_next : QM_CH_R1;
            out_last   <= (state_next == ST_SEND) && (idx_next == QM_CH_I3);
            drop_pulse <= drop;
        end
    end

    assign bus.OutValid  = out_valid;
    assign bus.OutData   = out_data;
    assign bus.OutChan   = out_chan;
    assign bus.OutLast   = out_last;
    assign bus.DropPulse = drop_pulse;
    assign bus.FrameCnt  = cnt;

`ifdef QMSER_DROP_COUNT_EN
    logic [15:0] drop_count;

    // Clear has priority over a coincident drop; the count saturates.
    always_ff @(posedge CLK) begin
        if (ARST)                                  drop_count <= '0;
        else if (bus.DropClr)                      drop_count <= '0;
        else if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end

    assign bus.DropCount = drop_count;
`endif

endmodule

// File: tb/tb_qm_out_serializer.sv
// Scoreboard bench for qm_out_serializer: stimulus pushes expected words,
// a negedge monitor pops and compares every accepted word.
module tb_qm_out_serializer;
    import qm_fir_pkg::*;

    localparam int OW = 16;
    localparam int DP = 4;

    logic CLK  = 1'b0;
    logic ARST = 1'b1;
    always #5 CLK = ~CLK;

    qm_out_serializer_if #(.OWIDTH(OW), .DEPTH(DP)) bus ();
    qm_out_serializer #(.OWIDTH(OW), .DEPTH(DP)) dut (
        .CLK  (CLK),
        .ARST (ARST),
        .bus  (bus)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  chan;
        logic        last;
    } word_t;

    word_t exp_q[$];
    word_t exp_w;
    word_t prev_w;
    logic  prev_stall = 1'b0;
    int    checks     = 0;
    int    failures   = 0;
    int    drops_seen = 0;
    int    drops0;
    bit    done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (ARST) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.DropPulse) drops_seen++;
            if (prev_stall) begin
                check("stall_valid", 32'(bus.OutValid), 32'd1);
                check("stall_hold", 32'({bus.OutData, bus.OutChan, bus.OutLast}), 32'(prev_w));
            end
            if (bus.OutValid && bus.OutReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got data=%0h chan=%0d expected none",
                             bus.OutData, bus.OutChan);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("word", 32'({bus.OutData, bus.OutChan, bus.OutLast}), 32'(exp_w));
                end
            end
            prev_stall = bus.OutValid && !bus.OutReady;
            prev_w     = {bus.OutData, bus.OutChan, bus.OutLast};
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [15:0] r1, i1, r2, i2, r3, i3, input bit accept);
        bus.RealIn1 = r1; bus.ImagIn1 = i1;
        bus.RealIn2 = r2; bus.ImagIn2 = i2;
        bus.RealIn3 = r3; bus.ImagIn3 = i3;
        bus.DataValid = 1'b1;
        if (accept) begin
            exp_q.push_back({r1, 3'd0, 1'b0});
            exp_q.push_back({i1, 3'd1, 1'b0});
            exp_q.push_back({r2, 3'd2, 1'b0});
            exp_q.push_back({i2, 3'd3, 1'b0});
            exp_q.push_back({r3, 3'd4, 1'b0});
            exp_q.push_back({i3, 3'd5, 1'b1});
        end
        tick();
        bus.DataValid = 1'b0;
    endtask

    task automatic send_base(input logic [15:0] base, input bit accept);
        send(base + 16'd1, base + 16'd2, base + 16'd3,
             base + 16'd4, base + 16'd5, base + 16'd6, accept);
    endtask

    task automatic drain(input string name);
        done = 1'b0;
        bus.OutReady = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (bus.FrameCnt == 0 && !bus.OutValid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        bus.DataValid = 1'b0;
        bus.RealIn1 = '0; bus.RealIn2 = '0; bus.RealIn3 = '0;
        bus.ImagIn1 = '0; bus.ImagIn2 = '0; bus.ImagIn3 = '0;
        bus.OutReady = 1'b0;
`ifdef QMSER_DROP_COUNT_EN
        bus.DropClr = 1'b0;
`endif
        repeat (3) tick();
        check("rst_valid", 32'(bus.OutValid), 32'd0);
        check("rst_data", 32'(bus.OutData), 32'd0);
        check("rst_chan", 32'(bus.OutChan), 32'd0);
        check("rst_last", 32'(bus.OutLast), 32'd0);
        check("rst_drop", 32'(bus.DropPulse), 32'd0);
        check("rst_cnt", 32'(bus.FrameCnt), 32'd0);
        ARST = 1'b0;
        tick();

        // single frame, ready high: R1 next cycle, I3 five cycles later
        bus.OutReady = 1'b1;
        send(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 1'b1);
        check("lat_valid", 32'(bus.OutValid), 32'd1);
        check("lat_data", 32'(bus.OutData), 32'h0001);
        check("lat_chan", 32'(bus.OutChan), 32'd0);
        check("lat_last", 32'(bus.OutLast), 32'd0);
        check("lat_cnt", 32'(bus.FrameCnt), 32'd1);
        repeat (5) tick();
        check("i3_data", 32'(bus.OutData), 32'h0006);
        check("i3_chan", 32'(bus.OutChan), 32'd5);
        check("i3_last", 32'(bus.OutLast), 32'd1);
        tick();
        check("single_cnt0", 32'(bus.FrameCnt), 32'd0);
        check("single_idle", 32'(bus.OutValid), 32'd0);

        // backpressure with ready pattern 1,0,0,1
        bus.OutReady = 1'b0;
        send_base(16'h0010, 1'b1);
        send_base(16'h0020, 1'b1);
        check("bp_cnt2", 32'(bus.FrameCnt), 32'd2);
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bus.OutReady = (i % 4 == 0) || (i % 4 == 3);
            tick();
            if (bus.FrameCnt == 0 && !bus.OutValid) begin
                done = 1'b1;
                break;
            end
        end
        check("bp_drained", 32'(done), 32'd1);

        // overflow: five frames into a depth-4 FIFO with ready low
        bus.OutReady = 1'b0;
        drops0 = drops_seen;
        send_base(16'h0030, 1'b1);
        send_base(16'h0040, 1'b1);
        send_base(16'h0050, 1'b1);
        send_base(16'h0060, 1'b1);
        check("ovf_nodrop", 32'(bus.DropPulse), 32'd0);
        send_base(16'h0070, 1'b0);
        check("ovf_drop", 32'(bus.DropPulse), 32'd1);
        check("ovf_cnt", 32'(bus.FrameCnt), 32'd4);
        tick();
        check("ovf_pulse_1cyc", 32'(bus.DropPulse), 32'd0);
`ifdef QMSER_DROP_COUNT_EN
        check("drop_count", 32'(bus.DropCount), 32'd1);
`endif

        // full FIFO plus write on the I3 transfer edge
        bus.OutReady = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.OutValid && bus.OutChan == 3'd5) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check("full_reach_i3", 32'(done), 32'd1);
        send_base(16'h0080, 1'b1);
        check("full_pop_nodrop", 32'(bus.DropPulse), 32'd0);
        check("full_pop_cnt", 32'(bus.FrameCnt), 32'd4);
        check("full_pop_next", 32'(bus.OutData), 32'h0041);
        drain("full_drained");
        check("drop_total", 32'(drops_seen - drops0), 32'd1);

        // negative samples, and back-to-back frames with no bubble
        bus.OutReady = 1'b0;
        send(16'h8000, 16'h1234, 16'h7FFF, 16'h0001, 16'hABCD, 16'hFFFF, 1'b1);
        send(16'hFFFE, 16'h8001, 16'h0000, 16'h5555, 16'hAAAA, 16'hC000, 1'b1);
        bus.OutReady = 1'b1;
        repeat (11) tick();
        check("b2b_valid", 32'(bus.OutValid), 32'd1);
        check("b2b_last", 32'({bus.OutData, bus.OutChan, bus.OutLast}), 32'({16'hC000, 3'd5, 1'b1}));
        tick();
        check("b2b_idle", 32'(bus.OutValid), 32'd0);

        // reset on the third word of a frame
        bus.OutReady = 1'b0;
        send_base(16'h0090, 1'b1);
        send_base(16'h00A0, 1'b1);
        bus.OutReady = 1'b1;
        tick();
        tick();
        check("pre_rst_chan", 32'(bus.OutChan), 32'd2);
        ARST = 1'b1;
        exp_q.delete();
        tick();
        check("mrst_valid", 32'(bus.OutValid), 32'd0);
        check("mrst_cnt", 32'(bus.FrameCnt), 32'd0);
        check("mrst_chan", 32'(bus.OutChan), 32'd0);
        ARST = 1'b0;
        tick();
        send_base(16'h00B0, 1'b1);
        check("post_rst_chan", 32'(bus.OutChan), 32'd0);
        check("post_rst_data", 32'(bus.OutData), 32'h00B1);
        drain("post_rst_drained");

        tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
